cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Instruction decoder and control FSM for the 16-bit SIMPLE RISC CPU. Takes the current
//  instruction from the external instruction register and issues, cycle by cycle, every
//  control input of the datapath: register-file ports, A/B/C/status enables, muxes, shift, ALUop.
//  Also drives the fetch/memory side: PC, IR and data-address-register enables, mem_cmd, addr_sel.
//  Moore machine: all outputs are a function of the state and the ir fields only.
// PARAMETERS
//  RESET_PC  8'h00  value the PC takes when reset_pc is asserted (forwarded to the PC logic)
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous, active-low reset
//  ir         in   16  current instruction: opcode[15:13] op[12:11] Rn[10:8] Rd[7:5] sh[4:3] Rm[2:0]
//  readnum    out  3   register-file read index
//  writenum   out  3   register-file write index
//  write      out  1   register-file write enable
//  vsel       out  2   writeback source: 00 = C, 01 = mdata, 10 = sximm8, 11 = PC
//  loada, loadb, loadc, loads  out  1 each  enables for the A, B, C and status registers
//  asel       out  1   1 = force the ALU A input to 0
//  bsel       out  2   00 = shifter, 01 = sximm5, 10 = sximm8
//  shift      out  2   shifter control
//  ALUop      out  2   00 = ADD, 01 = SUB, 10 = AND, 11 = NOT B
//  sximm8     out  16  sign-extended ir[7:0]
//  sximm5     out  16  sign-extended ir[4:0]
//  mem_cmd    out  2   00 = none, 01 = read, 10 = write
//  addr_sel   out  1   1 = memory address from PC; 0 = from the data address register
//  load_ir, load_pc, reset_pc, load_addr  out  1 each  fetch-side enables
//  halted     out  1   high while in the HALT state
// BEHAVIOUR
//  Outputs not listed for a state are 0, except: shift = ir[4:3] in GET_B for ALU-type
//  instructions and 00 otherwise; ALUop = ir[12:11] for opcode 101 and 00 otherwise.
//  reset_n low forces state RST immediately, including mid-instruction.
//  RST: reset_pc = 1, load_pc = 1. On the first clock edge after reset_n rises -> IF1.
//  Fetch, all instructions:
//   IF1: addr_sel = 1, mem_cmd = 01.
//   IF2: same as IF1, plus load_ir = 1.
//   UPDATE_PC: load_pc = 1.
//   DECODE: no outputs asserted; next state selected by {opcode, op}.
//  11010 MOV Rn,#i8: WRITE_IMM (writenum = Rn, vsel = 10, write = 1) -> IF1. 5 cycles total.
//  11000 MOV Rd,Rm,sh: GET_B -> CALC (asel = 1, bsel = 00, loadc = 1) -> WRITE_REG -> IF1. 7 cycles total.
//  101xx ALU: GET_A (readnum = Rn, loada = 1) -> GET_B (readnum = Rm, loadb = 1) -> CALC.
//   MVN (op = 11) skips GET_A and uses asel = 1.
//   CALC: bsel = 00, loadc = 1; for CMP (op = 01) loads = 1 and loadc = 0.
//   Then WRITE_REG (writenum = Rd, vsel = 00, write = 1) -> IF1. CMP goes CALC -> IF1.
//   Totals: ADD/AND 8 cycles, MVN 7 cycles, CMP 7 cycles.
//  01100 LDR Rd,[Rn,#i5]:
//   GET_A -> ADDR_CALC (bsel = 01, loadc = 1) -> LOAD_ADDR (load_addr = 1)
//   -> MEM_RD1 (addr_sel = 0, mem_cmd = 01)
//   -> MEM_RD2 (as MEM_RD1, plus vsel = 01, writenum = Rd, write = 1) -> IF1.
//  10000 STR Rd,[Rn,#i5]:
//   GET_A -> ADDR_CALC -> LOAD_ADDR -> GET_B (readnum = Rd, loadb = 1)
//   -> PASS (asel = 1, bsel = 00, shift = 00, loadc = 1)
//   -> MEM_WR (addr_sel = 0, mem_cmd = 10) -> IF1. Write data is the datapath output (C).
//  111xx HALT, and any undefined {opcode, op}: enter HALT. halted = 1 and all other outputs
//   are 0. HALT is left only by reset.
//  readnum and writenum are 0 in every state where they are not specified above.
//  write and mem_cmd = 10 are never asserted in the same cycle.
//  Each state lasts exactly one cycle. There are no wait states and no stall input.
// TESTING
//  Reset: reset_n = 0 -> RST, reset_pc = 1, load_pc = 1, halted = 0. After release, IF1 with mem_cmd = 01.
//  ir = 16'hD007 (MOV R0,#7): WRITE_IMM on cycle 5 with writenum = 0, vsel = 10,
//   sximm8 = 16'h0007, write = 1; IF1 on cycle 6.
//  ir = 16'hA148 (ADD R2,R1,R0,LSL#1): readnum 1 then 0, shift = 01 in GET_B,
//   ALUop = 00, then writenum = 2, write = 1; 8 cycles total.
//  ir = 16'hA900 (CMP R1,R0): ALUop = 01, loads = 1 in CALC, write never asserted; back in IF1 after 7 cycles.
//  ir = 16'h6162 (LDR R3,[R1,#2]), then 16'h8164 (STR R3,[R1,#4]): bsel = 01, sximm5 = 2 then 4.
//   LDR: MEM_RD2 has addr_sel = 0, vsel = 01, writenum = 3.
//   STR: MEM_WR has mem_cmd = 10, write = 0.
//  ir = 16'hE000: halted = 1 and held for 20 cycles.
//   Pulse reset_n low during ADD GET_B -> RST asynchronously; no write occurs.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: instruction decoder and control FSM for the 16-bit SIMPLE RISC CPU.
// It sequences fetch (IF1, IF2, UPDATE_PC, DECODE) and then the execute states of the
// current instruction, driving every datapath and fetch-side control input.
// Outputs are a Moore function of the state and the ir fields. State-dependent controls
// are registered: they are computed from the next state at the same edge that enters it.
// The sign-extended immediates and ALUop are plain ir fields, so they are driven
// combinationally from the current state and ir.
module cpu_controller #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ir,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [1:0]  mem_cmd,
  output logic        addr_sel,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        load_addr,
  output logic        halted,
  output logic [7:0]  reset_pc_value,
  output logic [4:0]  dbg_state
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM,
    S_GET_A, S_GET_B, S_CALC, S_WRITE_REG, S_ADDR_CALC, S_LOAD_ADDR,
    S_MEM_RD1, S_MEM_RD2, S_PASS, S_MEM_WR, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] bsel;
    logic [1:0] shift;
    logic [1:0] mem_cmd;
    logic       addr_sel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       halted;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;

  // Opcode classes used by both next-state and output decode.
  function automatic logic is_alu(input logic [15:0] v);
    return v[15:13] == 3'b101;
  endfunction

  // Instructions whose GET_B value passes through the shifter with the ir shift field:
  // the ALU group and the register MOV, which carries its own shift.
  function automatic logic uses_shift(input logic [15:0] v);
    return is_alu(v) || (v[15:11] == 5'b11000);
  endfunction

  // Next-state decode for every state.
  function automatic state_t next_state(input state_t s, input logic [15:0] v);
    state_t n;
    n = S_HALT;
    case (s)
      S_RST:       n = S_IF1;
      S_IF1:       n = S_IF2;
      S_IF2:       n = S_UPDATE_PC;
      S_UPDATE_PC: n = S_DECODE;
      S_DECODE: begin
        casez (v[15:11])
          5'b11010: n = S_WRITE_IMM;
          5'b11000: n = S_GET_B;
          5'b10111: n = S_GET_B;   // MVN has no A operand
          5'b101??: n = S_GET_A;
          5'b01100: n = S_GET_A;
          5'b10000: n = S_GET_A;
          default:  n = S_HALT;    // HALT and every undefined encoding
        endcase
      end
      S_WRITE_IMM: n = S_IF1;
      S_GET_A:     n = is_alu(v) ? S_GET_B : S_ADDR_CALC;
      S_GET_B:     n = (v[15:13] == 3'b100) ? S_PASS : S_CALC;
      S_CALC:      n = (v[15:11] == 5'b10101) ? S_IF1 : S_WRITE_REG;
      S_WRITE_REG: n = S_IF1;
      S_ADDR_CALC: n = S_LOAD_ADDR;
      S_LOAD_ADDR: n = (v[15:13] == 3'b100) ? S_GET_B : S_MEM_RD1;
      S_MEM_RD1:   n = S_MEM_RD2;
      S_MEM_RD2:   n = S_IF1;
      S_PASS:      n = S_MEM_WR;
      S_MEM_WR:    n = S_IF1;
      S_HALT:      n = S_HALT;
      default:     n = S_HALT;
    endcase
    return n;
  endfunction

  // Control word for a state; anything not named stays 0.
  function automatic ctl_t ctl_for(input state_t s, input logic [15:0] v);
    ctl_t c;
    c = '0;
    case (s)
      S_RST: begin
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
      end
      S_IF1: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = 2'b01;
      end
      S_IF2: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = 2'b01;
        c.load_ir  = 1'b1;
      end
      S_UPDATE_PC: c.load_pc = 1'b1;
      S_WRITE_IMM: begin
        c.writenum = v[10:8];
        c.vsel     = 2'b10;
        c.write    = 1'b1;
      end
      S_GET_A: begin
        c.readnum = v[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        // STR reads its store data from Rd; everything else reads Rm
        c.readnum = (v[15:13] == 3'b100) ? v[7:5] : v[2:0];
        c.loadb   = 1'b1;
        c.shift   = uses_shift(v) ? v[4:3] : 2'b00;
      end
      S_CALC: begin
        c.asel = (v[15:11] == 5'b11000) || (v[15:11] == 5'b10111);
        c.bsel = 2'b00;
        if (v[15:11] == 5'b10101) c.loads = 1'b1;
        else                      c.loadc = 1'b1;
      end
      S_WRITE_REG: begin
        c.writenum = v[7:5];
        c.vsel     = 2'b00;
        c.write    = 1'b1;
      end
      S_ADDR_CALC: begin
        c.bsel  = 2'b01;
        c.loadc = 1'b1;
      end
      S_LOAD_ADDR: c.load_addr = 1'b1;
      S_MEM_RD1: begin
        c.addr_sel = 1'b0;
        c.mem_cmd  = 2'b01;
      end
      S_MEM_RD2: begin
        c.addr_sel = 1'b0;
        c.mem_cmd  = 2'b01;
        c.vsel     = 2'b01;
        c.writenum = v[7:5];
        c.write    = 1'b1;
      end
      S_PASS: begin
        c.asel  = 1'b1;
        c.bsel  = 2'b00;
        c.loadc = 1'b1;
      end
      S_MEM_WR: c.mem_cmd = 2'b10;
      S_HALT:   c.halted  = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next state from the current state and instruction.
  always_comb begin
    nxt = next_state(state, ir);
  end

  // State register and registered control word; reset lands in RST at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_RST;
      ctl_q            <= '0;
      ctl_q.reset_pc   <= 1'b1;
      ctl_q.load_pc    <= 1'b1;
    end else begin
      state <= nxt;
      ctl_q <= ctl_for(nxt, ir);
    end
  end

  assign readnum   = ctl_q.readnum;
  assign writenum  = ctl_q.writenum;
  assign write     = ctl_q.write;
  assign vsel      = ctl_q.vsel;
  assign loada     = ctl_q.loada;
  assign loadb     = ctl_q.loadb;
  assign loadc     = ctl_q.loadc;
  assign loads     = ctl_q.loads;
  assign asel      = ctl_q.asel;
  assign bsel      = ctl_q.bsel;
  assign shift     = ctl_q.shift;
  assign mem_cmd   = ctl_q.mem_cmd;
  assign addr_sel  = ctl_q.addr_sel;
  assign load_ir   = ctl_q.load_ir;
  assign load_pc   = ctl_q.load_pc;
  assign reset_pc  = ctl_q.reset_pc;
  assign load_addr = ctl_q.load_addr;
  assign halted    = ctl_q.halted;

  // Immediate and ALU-op fields; forced to 0 in HALT so the halted machine drives nothing.
  assign sximm8 = (state == S_HALT) ? 16'h0000 : {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = (state == S_HALT) ? 16'h0000 : {{11{ir[4]}}, ir[4:0]};
  assign ALUop  = (state != S_HALT && is_alu(ir)) ? ir[12:11] : 2'b00;

  // PC reset value handed to the PC register logic.
  assign reset_pc_value = RESET_PC;
  assign dbg_state      = state;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller. A driver issues instructions and, at issue time, pushes the
// expected control word of every cycle the instruction occupies; a monitor pops one word
// per cycle on the falling edge and compares it with the DUT outputs.
module tb_cpu_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] ir;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel;
  logic [1:0]  vsel, bsel, shift, alu_op, mem_cmd;
  logic [15:0] sximm8, sximm5;
  logic        addr_sel, load_ir, load_pc, reset_pc, load_addr, halted;
  logic [7:0]  reset_pc_value;
  logic [4:0]  dbg_state;

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  bsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [1:0]  mem_cmd;
    logic        addr_sel;
    logic        load_ir;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic        halted;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic [W-1:0] exp_q[$];
  int           checks;
  int           passes;
  logic         mon_en;
  logic [15:0]  ir_cur;

  cpu_controller #(.RESET_PC(8'h00)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir             (ir),
    .readnum        (readnum),
    .writenum       (writenum),
    .write          (write),
    .vsel           (vsel),
    .loada          (loada),
    .loadb          (loadb),
    .loadc          (loadc),
    .loads          (loads),
    .asel           (asel),
    .bsel           (bsel),
    .shift          (shift),
    .ALUop          (alu_op),
    .sximm8         (sximm8),
    .sximm5         (sximm5),
    .mem_cmd        (mem_cmd),
    .addr_sel       (addr_sel),
    .load_ir        (load_ir),
    .load_pc        (load_pc),
    .reset_pc       (reset_pc),
    .load_addr      (load_addr),
    .halted         (halted),
    .reset_pc_value (reset_pc_value),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model helpers ----------------
  // Fields every non-halted cycle shows: immediates and the ALU op follow ir.
  function automatic obs_t base(input logic [15:0] v);
    obs_t o;
    o        = '0;
    o.sximm8 = {{8{v[7]}}, v[7:0]};
    o.sximm5 = {{11{v[4]}}, v[4:0]};
    o.alu_op = (v[15:13] == 3'b101) ? v[12:11] : 2'b00;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.readnum   = readnum;
    o.writenum  = writenum;
    o.write     = write;
    o.vsel      = vsel;
    o.loada     = loada;
    o.loadb     = loadb;
    o.loadc     = loadc;
    o.loads     = loads;
    o.asel      = asel;
    o.bsel      = bsel;
    o.shift     = shift;
    o.alu_op    = alu_op;
    o.sximm8    = sximm8;
    o.sximm5    = sximm5;
    o.mem_cmd   = mem_cmd;
    o.addr_sel  = addr_sel;
    o.load_ir   = load_ir;
    o.load_pc   = load_pc;
    o.reset_pc  = reset_pc;
    o.load_addr = load_addr;
    o.halted    = halted;
    return o;
  endfunction

  function automatic obs_t rst_word(input logic [15:0] v);
    obs_t o;
    o          = base(v);
    o.reset_pc = 1'b1;
    o.load_pc  = 1'b1;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  // Pushes the fetch words (IF1/IF2 still see the previous ir, the new one arrives with
  // load_ir) plus UPDATE_PC and DECODE. Returns the number pushed.
  task automatic push_fetch(input logic [15:0] nv, output int n);
    obs_t o;
    o = base(ir_cur); o.addr_sel = 1'b1; o.mem_cmd = 2'b01;
    exp_q.push_back(o);
    o.load_ir = 1'b1;
    exp_q.push_back(o);
    o = base(nv); o.load_pc = 1'b1;
    exp_q.push_back(o);
    o = base(nv);
    exp_q.push_back(o);
    n = 4;
  endtask

  // Expected execute words for one instruction, from its mnemonic-level behaviour.
  task automatic push_exec(input logic [15:0] nv, input int halt_cycles, inout int n);
    obs_t o;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    opc = nv[15:13]; op = nv[12:11]; rn = nv[10:8]; rd = nv[7:5]; rm = nv[2:0];
    if ({opc, op} == 5'b11010) begin                       // MOV Rn,#i8
      o = base(nv); o.writenum = rn; o.vsel = 2'b10; o.write = 1'b1;
      exp_q.push_back(o); n++;
    end else if ({opc, op} == 5'b11000) begin              // MOV Rd,Rm,sh
      o = base(nv); o.readnum = rm; o.loadb = 1'b1; o.shift = nv[4:3];
      exp_q.push_back(o); n++;
      o = base(nv); o.asel = 1'b1; o.loadc = 1'b1;
      exp_q.push_back(o); n++;
      o = base(nv); o.writenum = rd; o.write = 1'b1;
      exp_q.push_back(o); n++;
    end else if (opc == 3'b101) begin                      // ADD / CMP / AND / MVN
      if (op != 2'b11) begin
        o = base(nv); o.readnum = rn; o.loada = 1'b1;
        exp_q.push_back(o); n++;
      end
      o = base(nv); o.readnum = rm; o.loadb = 1'b1; o.shift = nv[4:3];
      exp_q.push_back(o); n++;
      o = base(nv); o.asel = (op == 2'b11);
      if (op == 2'b01) o.loads = 1'b1; else o.loadc = 1'b1;
      exp_q.push_back(o); n++;
      if (op != 2'b01) begin
        o = base(nv); o.writenum = rd; o.write = 1'b1;
        exp_q.push_back(o); n++;
      end
    end else if ({opc, op} == 5'b01100 || {opc, op} == 5'b10000) begin  // LDR / STR
      o = base(nv); o.readnum = rn; o.loada = 1'b1;
      exp_q.push_back(o); n++;
      o = base(nv); o.bsel = 2'b01; o.loadc = 1'b1;
      exp_q.push_back(o); n++;
      o = base(nv); o.load_addr = 1'b1;
      exp_q.push_back(o); n++;
      if (opc == 3'b011) begin
        o = base(nv); o.mem_cmd = 2'b01;
        exp_q.push_back(o); n++;
        o.vsel = 2'b01; o.writenum = rd; o.write = 1'b1;
        exp_q.push_back(o); n++;
      end else begin
        o = base(nv); o.readnum = rd; o.loadb = 1'b1;
        exp_q.push_back(o); n++;
        o = base(nv); o.asel = 1'b1; o.loadc = 1'b1;
        exp_q.push_back(o); n++;
        o = base(nv); o.mem_cmd = 2'b10;
        exp_q.push_back(o); n++;
      end
    end else begin                                         // HALT / undefined
      o = '0; o.halted = 1'b1;
      for (int i = 0; i < halt_cycles; i++) begin
        exp_q.push_back(o); n++;
      end
    end
  endtask

  // Starts at posedge+1 with the DUT in IF1; ends at posedge+1 after n cycles.
  task automatic issue(input logic [15:0] nv, input int halt_cycles);
    int n;
    push_fetch(nv, n);
    push_exec(nv, halt_cycles, n);
    @(posedge clk);
    @(posedge clk);
    #1;
    ir     = nv;
    ir_cur = nv;
    repeat (n - 2) @(posedge clk);
    #1;
  endtask

  // Async reset pulse inside one cycle; expects one RST word, then IF1 follows.
  task automatic apply_reset();
    exp_q.push_back(rst_word(ir_cur));
    reset_n = 1'b0;
    #6;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ADD issued, reset pulsed while it sits in GET_B: no CALC or write may follow.
  task automatic issue_add_then_reset(input logic [15:0] nv);
    int n;
    obs_t o;
    push_fetch(nv, n);
    o = base(nv); o.readnum = nv[10:8]; o.loada = 1'b1;
    exp_q.push_back(o);
    @(posedge clk);
    @(posedge clk);
    #1;
    ir     = nv;
    ir_cur = nv;
    repeat (3) @(posedge clk);
    #1;
    apply_reset();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0]  cls;
    logic [10:0] low;
    case ($urandom_range(0, 7))
      0:       cls = 5'b11010;
      1:       cls = 5'b11000;
      2:       cls = 5'b10100;
      3:       cls = 5'b10101;
      4:       cls = 5'b10110;
      5:       cls = 5'b10111;
      6:       cls = 5'b01100;
      default: cls = 5'b10000;
    endcase
    low = 11'($urandom);
    return {cls, low};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL queue_underflow t=%0t got=%h required=<no expected word>", $time, sample());
        end else begin
          e   = exp_q.pop_front();
          got = sample();
          if (got === e) passes++;
          else $display("FAIL cycle_word #%0d t=%0t dbg_state=%0d got=%h required=%h",
                        checks, $time, dbg_state, got, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks  = 0;
    passes  = 0;
    ir      = 16'h0000;
    ir_cur  = 16'h0000;
    reset_n = 1'b0;
    mon_en  = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(rst_word(16'h0000));
    #32;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // directed programme
    issue(16'hD007, 0);            // MOV R0,#7
    issue(16'hA148, 0);            // ADD R2,R1,R0,LSL#1
    issue(16'hA900, 0);            // CMP R1,R0
    issue(16'h6162, 0);            // LDR R3,[R1,#2]
    issue(16'h8164, 0);            // STR R3,[R1,#4]
    issue(16'hD0F0, 0);            // MOV R0,#-16 (negative immediate)
    issue(16'hB81F, 0);            // MVN R0,R7 with shift bits set
    issue(16'hC07B, 0);            // MOV R3,R3,shift 11
    issue_add_then_reset(16'hA148);

    // randomized mix
    for (int i = 0; i < 40; i++) issue(rand_instr(), 0);

    // undefined encoding halts until reset
    issue(16'h0000, 4);
    apply_reset();
    issue(16'hD5AA, 0);

    // HALT held for 20 cycles
    issue(16'hE000, 20);

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL queue_drain got=%0d words left required=0", exp_q.size());
    checks++;
    if (reset_pc_value === 8'h00) passes++;
    else $display("FAIL reset_pc_value got=%h required=00", reset_pc_value);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
